// File: rtl/decode_stage_if.sv
// Handshake and decoded-entry bundle between fetch, decode and the downstream stage.
// The slave view belongs to the decoder; the master view belongs to its surroundings.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_class;
    logic            out_word;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_rs1_valid;
    logic            out_rs2_valid;
    logic            out_rd_valid;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_alu_bits;
    logic [6:0]      out_funct7;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_class, out_word,
               out_rs1, out_rs2, out_rd, out_rs1_valid, out_rs2_valid,
               out_rd_valid, out_imm, out_alu_bits, out_funct7
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_class, out_word,
               out_rs1, out_rs2, out_rd, out_rs1_valid, out_rs2_valid,
               out_rd_valid, out_imm, out_alu_bits, out_funct7
    );
endinterface

// File: rtl/decode_stage.sv
// RISC-V instruction decode stage: combinational field decode feeding a
// registered output slot backed by a one-entry skid register.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_R       = 4'd1;
    localparam logic [3:0] CLS_OPIMM   = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JAL     = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_LUI     = 4'd8;
    localparam logic [3:0] CLS_AUIPC   = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      cls;
        logic            word;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            rd_valid;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_bits;
        logic [6:0]      funct7;
    } entry_t;

    entry_t          dec;
    entry_t          out_d, out_q;
    entry_t          skid_d, skid_q;
    logic            out_valid_d, out_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic            in_ready_d, in_ready_q;
    logic            in_fire;
    logic            out_free;
    logic [4:0]      opcode;
    logic [31:0]     imm_i, imm_s, imm_b, imm_j, imm_u;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Pure combinational decode of the offered instruction word.
    always_comb begin
        opcode = bus.in_instr[6:2];
        imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        imm_s  = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        imm_b  = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                  bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        imm_j  = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                  bus.in_instr[20], bus.in_instr[30:21], 1'b0};
        imm_u  = {bus.in_instr[31:12], 12'b0};

        dec           = '0;
        dec.pc        = bus.in_pc;
        dec.rs1       = bus.in_instr[19:15];
        dec.rs2       = bus.in_instr[24:20];
        dec.rd        = bus.in_instr[11:7];
        dec.alu_bits  = {bus.in_instr[30], bus.in_instr[14:12]};
        dec.funct7    = bus.in_instr[31:25];

        if (bus.in_instr[1:0] == 2'b11) begin
            unique case (opcode)
                5'b00000: begin
                    dec.cls       = CLS_LOAD;
                    dec.imm       = sext32(imm_i);
                    dec.rs1_valid = 1'b1;
                    dec.rd_valid  = 1'b1;
                end
                5'b00100: begin
                    dec.cls       = CLS_OPIMM;
                    dec.imm       = sext32(imm_i);
                    dec.rs1_valid = 1'b1;
                    dec.rd_valid  = 1'b1;
                end
                5'b00110: begin
                    if (XLEN == 64) begin
                        dec.cls       = CLS_OPIMM;
                        dec.word      = 1'b1;
                        dec.imm       = sext32(imm_i);
                        dec.rs1_valid = 1'b1;
                        dec.rd_valid  = 1'b1;
                    end
                end
                5'b00101: begin
                    dec.cls      = CLS_AUIPC;
                    dec.imm      = sext32(imm_u);
                    dec.rd_valid = 1'b1;
                end
                5'b01000: begin
                    dec.cls       = CLS_STORE;
                    dec.imm       = sext32(imm_s);
                    dec.rs1_valid = 1'b1;
                    dec.rs2_valid = 1'b1;
                end
                5'b01100: begin
                    dec.cls       = CLS_R;
                    dec.rs1_valid = 1'b1;
                    dec.rs2_valid = 1'b1;
                    dec.rd_valid  = 1'b1;
                end
                5'b01110: begin
                    if (XLEN == 64) begin
                        dec.cls       = CLS_R;
                        dec.word      = 1'b1;
                        dec.rs1_valid = 1'b1;
                        dec.rs2_valid = 1'b1;
                        dec.rd_valid  = 1'b1;
                    end
                end
                5'b01101: begin
                    dec.cls      = CLS_LUI;
                    dec.imm      = sext32(imm_u);
                    dec.rd_valid = 1'b1;
                end
                5'b11000: begin
                    dec.cls       = CLS_BRANCH;
                    dec.imm       = sext32(imm_b);
                    dec.rs1_valid = 1'b1;
                    dec.rs2_valid = 1'b1;
                end
                5'b11001: begin
                    dec.cls       = CLS_JALR;
                    dec.imm       = sext32(imm_i);
                    dec.rs1_valid = 1'b1;
                    dec.rd_valid  = 1'b1;
                end
                5'b11011: begin
                    dec.cls      = CLS_JAL;
                    dec.imm      = sext32(imm_j);
                    dec.rd_valid = 1'b1;
                end
                default: dec.cls = CLS_ILLEGAL;
            endcase
        end

        // Writes to x0 are architecturally discarded, so never flag them as a destination.
        if (dec.rd == 5'd0) begin
            dec.rd_valid = 1'b0;
        end
    end

    always_comb begin
        in_fire      = bus.in_valid & bus.in_ready;
        out_free     = !out_valid_q | bus.out_ready;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        // The skid register only fills while the output slot is stalled, so
        // a full skid implies in_ready was low and no input can arrive with it.
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = dec;
                end
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Reset gating keeps the stage closed while held in reset, independent of out_ready.
    assign bus.in_ready      = in_ready_q & ~rst;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_q.pc;
    assign bus.out_class     = out_q.cls;
    assign bus.out_word      = out_q.word;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_rs1_valid = out_q.rs1_valid;
    assign bus.out_rs2_valid = out_q.rs2_valid;
    assign bus.out_rd_valid  = out_q.rd_valid;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_alu_bits  = out_q.alu_bits;
    assign bus.out_funct7    = out_q.funct7;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, backpressure, flush and reset,
// with a second XLEN=64 instance for word-op and wide sign extension.
module tb_decode_stage;

    logic clk;
    logic rst;
    int   evals;
    int   fails;

    decode_stage_if #(.XLEN(32)) bus32 ();
    decode_stage_if #(.XLEN(64)) bus64 ();

    decode_stage #(.XLEN(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic ready,
                                 input logic fl);
        bus32.in_valid  = valid;
        bus32.in_instr  = instr;
        bus32.in_pc     = pc;
        bus32.out_ready = ready;
        bus32.flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        evals++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one instruction with out_ready high and check the entry one cycle later.
    task automatic decodeOne(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [3:0] cls,
                             input logic [31:0] imm, input logic [2:0] vld);
        applyStimulus(1'b1, instr, pc, 1'b1, 1'b0);
        tick();
        checkOutput({tag, "_valid"}, 64'(bus32.out_valid), 64'd1);
        checkOutput({tag, "_class"}, 64'(bus32.out_class), 64'(cls));
        checkOutput({tag, "_imm"},   64'(bus32.out_imm),   64'(imm));
        checkOutput({tag, "_pc"},    64'(bus32.out_pc),    64'(pc));
        checkOutput({tag, "_vld"},
                    64'({bus32.out_rs1_valid, bus32.out_rs2_valid, bus32.out_rd_valid}),
                    64'(vld));
    endtask

    initial begin
        evals = 0;
        fails = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = 32'h0;
        bus64.in_pc     = 64'h0;
        bus64.out_ready = 1'b1;
        bus64.flush     = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_in_ready",  64'(bus32.in_ready),  64'd0);
        checkOutput("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("rst_out_pc",    64'(bus32.out_pc),    64'd0);
        checkOutput("rst_out_imm",   64'(bus32.out_imm),   64'd0);
        checkOutput("rst_out_class", 64'(bus32.out_class), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", 64'(bus32.in_ready), 64'd1);

        // addi x1,x0,5
        decodeOne("addi", 32'h0050_0093, 32'h0000_0100, 4'd2, 32'd5, 3'b101);
        checkOutput("addi_rd",  64'(bus32.out_rd),  64'd1);
        checkOutput("addi_rs1", 64'(bus32.out_rs1), 64'd0);

        // Immediate formats, back to back
        decodeOne("addi_m1", 32'hFFF1_0113, 32'h0000_0104, 4'd2, 32'hFFFF_FFFF, 3'b101);
        decodeOne("beq",     32'hFE00_0EE3, 32'h0000_0108, 4'd5, 32'hFFFF_FFFC, 3'b110);
        decodeOne("sw",      32'h0051_2623, 32'h0000_010C, 4'd4, 32'd12,        3'b110);
        checkOutput("sw_rs1", 64'(bus32.out_rs1), 64'd2);
        checkOutput("sw_rs2", 64'(bus32.out_rs2), 64'd5);
        decodeOne("jal",     32'h0080_00EF, 32'h0000_0110, 4'd6, 32'd8,         3'b001);
        decodeOne("nop",     32'h0000_0013, 32'h0000_0114, 4'd2, 32'd0,         3'b100);
        decodeOne("addiw32", 32'h0010_009B, 32'h0000_0118, 4'd0, 32'd0,         3'b000);
        checkOutput("addiw32_word", 64'(bus32.out_word), 64'd0);
        decodeOne("badlow",  32'h0050_0090, 32'h0000_011C, 4'd0, 32'd0,         3'b000);
        decodeOne("lui",     32'h1234_50B7, 32'h0000_0120, 4'd8, 32'h1234_5000, 3'b001);
        decodeOne("auipc",   32'h8000_0117, 32'h0000_0124, 4'd9, 32'h8000_0000, 3'b001);
        decodeOne("jalr",    32'h0000_80E7, 32'h0000_0128, 4'd7, 32'd0,         3'b101);
        decodeOne("sub",     32'h40B5_0533, 32'h0000_012C, 4'd1, 32'd0,         3'b111);
        checkOutput("sub_alu_bits", 64'(bus32.out_alu_bits), 64'h8);
        checkOutput("sub_funct7",   64'(bus32.out_funct7),   64'h20);
        checkOutput("sub_rd",       64'(bus32.out_rd),       64'd10);
        decodeOne("lw",      32'hFFC4_2503, 32'h0000_0130, 4'd3, 32'hFFFF_FFFC, 3'b101);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("idle_out_valid", 64'(bus32.out_valid), 64'd0);

        // Backpressure: two accepted, third refused, ordered drain
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0, 1'b0);
        tick();
        checkOutput("bp_a_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("bp_a_pc",       64'(bus32.out_pc),   64'h200);
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0204, 1'b0, 1'b0);
        tick();
        checkOutput("bp_b_in_ready", 64'(bus32.in_ready), 64'd0);
        checkOutput("bp_b_hold_pc",  64'(bus32.out_pc),   64'h200);
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0208, 1'b0, 1'b0);
        tick();
        checkOutput("bp_c_in_ready", 64'(bus32.in_ready),  64'd0);
        checkOutput("bp_c_hold_pc",  64'(bus32.out_pc),    64'h200);
        checkOutput("bp_c_valid",    64'(bus32.out_valid), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_drain1_pc",       64'(bus32.out_pc),    64'h204);
        checkOutput("bp_drain1_valid",    64'(bus32.out_valid), 64'd1);
        checkOutput("bp_drain1_in_ready", 64'(bus32.in_ready),  64'd1);
        tick();
        checkOutput("bp_drain2_valid", 64'(bus32.out_valid), 64'd0);

        // Flush with two entries held and an input offered
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0304, 1'b0, 1'b0);
        tick();
        checkOutput("fl_full_in_ready", 64'(bus32.in_ready), 64'd0);
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0308, 1'b0, 1'b1);
        tick();
        checkOutput("fl_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("fl_in_ready",  64'(bus32.in_ready),  64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_after_valid", 64'(bus32.out_valid), 64'd0);
        applyStimulus(1'b1, 32'h0000_0013, 32'h0000_0400, 1'b1, 1'b1);
        tick();
        checkOutput("fl_discard_valid", 64'(bus32.out_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_discard_after", 64'(bus32.out_valid), 64'd0);

        // Reset with an entry held
        applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0500, 1'b0, 1'b0);
        tick();
        checkOutput("mr_held_valid", 64'(bus32.out_valid), 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("mr_in_ready_low", 64'(bus32.in_ready), 64'd0);
        tick();
        checkOutput("mr_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("mr_out_pc",    64'(bus32.out_pc),    64'd0);
        checkOutput("mr_out_imm",   64'(bus32.out_imm),   64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mr_in_ready_high", 64'(bus32.in_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("mr_nothing_emerges", 64'(bus32.out_valid), 64'd0);

        // XLEN=64 instance: word op and wide sign extension
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h0010_009B;
        bus64.in_pc    = 64'h8000_0000_0000_0010;
        tick();
        checkOutput("x64_addiw_valid", 64'(bus64.out_valid), 64'd1);
        checkOutput("x64_addiw_class", 64'(bus64.out_class), 64'd2);
        checkOutput("x64_addiw_word",  64'(bus64.out_word),  64'd1);
        checkOutput("x64_addiw_imm",   bus64.out_imm,        64'd1);
        checkOutput("x64_addiw_pc",    bus64.out_pc,         64'h8000_0000_0000_0010);
        bus64.in_instr = 32'hFFF1_0113;
        bus64.in_pc    = 64'h8000_0000_0000_0014;
        tick();
        checkOutput("x64_addi_imm",  bus64.out_imm,       64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("x64_addi_word", 64'(bus64.out_word), 64'd0);
        bus64.in_instr = 32'h8000_0117;
        bus64.in_pc    = 64'h8000_0000_0000_0018;
        tick();
        checkOutput("x64_auipc_imm", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
        bus64.in_valid = 1'b0;
        tick();
        checkOutput("x64_idle_valid", 64'(bus64.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  upstream instruction present.
REQ-005 Port in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
REQ-006 Port in_instr  input  32  raw instruction word.
REQ-007 Port in_pc  input  XLEN  instruction address.
REQ-008 Port flush  input  1  discard all held and incoming instructions.
REQ-009 Port out_valid  output  1  decoded entry present.
REQ-010 Port out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-011 Port out_pc  output  XLEN  PC of the entry.
REQ-012 Port out_class  output  4  0 illegal, 1 R, 2 OP-IMM, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC.
REQ-013 Port out_word  output  1  32-bit word op (OP-32/OP-IMM-32); XLEN=64 only.
REQ-014 Port out_rs1, out_rs2, out_rd  output  5 each  register fields instr[19:15], [24:20], [11:7].
REQ-015 Port out_rs1_valid, out_rs2_valid, out_rd_valid  output  1 each  operand/destination used.
REQ-016 Port out_imm  output  XLEN  sign-extended immediate.
REQ-017 Port out_alu_bits  output  4  {instr[30], instr[14:12]}.
REQ-018 Port out_funct7  output  7  instr[31:25].

Function
REQ-019 Decode SHALL use opcode = instr[6:2]; instr[1:0] != 2'b11 SHALL give class 0.
REQ-020 Opcode map: 00000 LOAD, 00100 OP-IMM, 00101 AUIPC, 01000 STORE, 01100 R, 01101 LUI, 11000 BRANCH, 11001 JALR, 11011 JAL; 00110 -> OP-IMM and 01110 -> R with out_word=1 only when XLEN=64, else class 0; all other opcodes class 0.
REQ-021 Immediates (bit 31 sign-extended to XLEN): I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0} sign-extended; R and class 0 give imm 0.
REQ-022 rs1_valid for R, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2_valid for R, STORE, BRANCH; rd_valid for R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC and only when rd != 0; all valids 0 for class 0.
REQ-023 Decoded fields SHALL be registered; latency exactly 1 cycle from input transfer to out_valid.
REQ-024 Storage: one output register plus one skid register; in_ready = !skid_full, registered, not depending combinationally on out_ready.
REQ-025 Input transfer while output is empty or draining the same cycle SHALL load the output register; otherwise load the skid register.
REQ-026 Output transfer with skid full SHALL move skid to output next cycle, in_ready returning to 1 that cycle.
REQ-027 Order SHALL be preserved; no entry dropped or duplicated except by flush/reset.
REQ-028 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-029 flush=1 SHALL clear output and skid next cycle (out_valid=0, in_ready=1); an input offered in the flush cycle SHALL be discarded; flush overrides simultaneous transfers.
REQ-030 Illegal instructions SHALL pass through as normal entries with class 0.

Reset
REQ-031 While rst=1: in_ready=0; next cycle out_valid=0, skid empty, all data outputs 0.
REQ-032 Reset mid-operation SHALL discard held entries; first cycle after rst deasserts in_ready=1.

Verification
REQ-033 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, class 2, rd=1, rs1=0, rs1_valid=1, rd_valid=1, imm=5.
REQ-034 0xFFF10113, 0xFE000EE3, 0x00512623, 0x008000EF -> imm all-ones, 0x...FFFC (B), 12 (S), 8 (J) with classes 2,5,4,6.
REQ-035 out_ready=0, three back-to-back inputs -> two accepted, in_ready=0 on third; then out_ready=1 -> entries in order, in_ready=1 one cycle after first drain.
REQ-036 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing from either emerges.
REQ-037 0x0010009B (addiw): XLEN=64 -> class 2, out_word=1; XLEN=32 -> class 0; 0x00000013 -> rd_valid=0.
REQ-038 rst asserted with entry held -> out_valid=0 after edge, in_ready=1 after deassert.
